// File: rtl/fpmac_result_checker.sv
// rtl/fpmac_result_checker.sv - delayed-expected-value scoreboard for the FP16 fpmac output
module fpmac_result_checker #(
    parameter int LATENCY = 11,
    parameter int IDX_W   = 16
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic             stop,
    input  logic             exp_valid,
    input  logic [15:0]      exp_data,
    input  logic [15:0]      out,
    input  logic             overflow,
    input  logic             sub,
    output logic             busy,
    output logic             done,
    output logic             err_flag,
    output logic [IDX_W-1:0] pass_cnt,
    output logic [IDX_W-1:0] fail_cnt,
    output logic [IDX_W-1:0] sub_cnt,
    output logic [IDX_W-1:0] first_fail_idx,
    output logic [15:0]      first_fail_got,
    output logic [15:0]      first_fail_exp
);

    if (LATENCY < 1 || LATENCY > 32) begin : g_latency_check
        $error("fpmac_result_checker: LATENCY must be in 1..32");
    end

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;

    state_t             state_q, state_d;
    logic               busy_q, done_q, err_q;
    logic [LATENCY-1:0] vld_q;
    logic [15:0]        dat_q [LATENCY];
    logic [IDX_W-1:0]   idx_q [LATENCY];
    logic [IDX_W-1:0]   issue_idx_q;
    logic [IDX_W-1:0]   pass_q, fail_q, sub_q, ff_idx_q;
    logic [15:0]        ff_got_q, ff_exp_q;

    logic               accept, clear_run, pending;
    logic               cmp_valid, cmp_pass;
    logic [15:0]        cmp_exp;

    assign accept    = exp_valid && (state_q == S_RUN);
    assign cmp_valid = vld_q[LATENCY-1];
    assign cmp_exp   = dat_q[LATENCY-1];
    assign cmp_pass  = (out == cmp_exp) || (out == cmp_exp + 16'd1)
                     || (overflow && (cmp_exp[14:10] == 5'h1f));

    // Entries still upstream of the compare stage after this edge.
    always_comb begin
        pending = 1'b0;
        for (int i = 0; i < LATENCY - 1; i++) begin
            pending = pending | vld_q[i];
        end
    end

    always_comb begin
        state_d   = state_q;
        clear_run = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d   = S_RUN;
                    clear_run = 1'b1;
                end
            end
            S_RUN: begin
                if (stop) state_d = S_DRAIN;
            end
            S_DRAIN: begin
                if (!pending) state_d = S_DONE;
            end
            S_DONE: begin
                if (start) begin
                    state_d   = S_RUN;
                    clear_run = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= (state_d == S_RUN) || (state_d == S_DRAIN);
            done_q  <= (state_d == S_DONE);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            vld_q <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                dat_q[i] <= '0;
                idx_q[i] <= '0;
            end
        end else begin
            for (int i = LATENCY - 1; i > 0; i--) begin
                vld_q[i] <= vld_q[i-1];
                dat_q[i] <= dat_q[i-1];
                idx_q[i] <= idx_q[i-1];
            end
            vld_q[0] <= accept;
            dat_q[0] <= exp_data;
            idx_q[0] <= issue_idx_q;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST || clear_run) begin
            issue_idx_q <= '0;
        end else if (accept) begin
            issue_idx_q <= issue_idx_q + IDX_W'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST || clear_run) begin
            pass_q   <= '0;
            fail_q   <= '0;
            sub_q    <= '0;
            err_q    <= 1'b0;
            ff_idx_q <= '0;
            ff_got_q <= '0;
            ff_exp_q <= '0;
        end else if (cmp_valid) begin
            if (cmp_pass) begin
                if (pass_q != '1) pass_q <= pass_q + IDX_W'(1);
            end else begin
                if (fail_q != '1) fail_q <= fail_q + IDX_W'(1);
                if (!err_q) begin
                    err_q    <= 1'b1;
                    ff_idx_q <= idx_q[LATENCY-1];
                    ff_got_q <= out;
                    ff_exp_q <= cmp_exp;
                end
            end
            if (sub && (sub_q != '1)) sub_q <= sub_q + IDX_W'(1);
        end
    end

    assign busy           = busy_q;
    assign done           = done_q;
    assign err_flag       = err_q;
    assign pass_cnt       = pass_q;
    assign fail_cnt       = fail_q;
    assign sub_cnt        = sub_q;
    assign first_fail_idx = ff_idx_q;
    assign first_fail_got = ff_got_q;
    assign first_fail_exp = ff_exp_q;

endmodule
